bcd_sync_display: RTL and testbench

//  Downstream consumer of the asynchronous decade (ripple) counter outputs Y3..Y0.
//  - Resynchronises the ripple-changing BCD code into the clock domain.
//  - Filters intermediate ripple codes; flags illegal codes (10-15).
//  - Extends the count with a synchronous tens digit on each 9->0 wrap.
//  - Drives a 2-digit time-multiplexed 7-segment display.

---
 rtl/bcd_disp_pkg.sv | 50 +++++
 rtl/bcd_stable_sampler.sv | 73 +++++++
 rtl/bcd_sync_display.sv | 107 ++++++++++
 tb/tb_bcd_sync_display.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the 7-segment BCD display blocks.
package bcd_disp_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned AN_W    = 2;

   // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   // One-hot digit enables
   localparam logic [AN_W-1:0] AN_ONES = 2'b01;
   localparam logic [AN_W-1:0] AN_TENS = 2'b10;

   // Two-digit decimal value carried between the counter and the display mux
   typedef struct packed {
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] ones;
   } bcd_pair_t;

   // BCD digit to segment pattern; codes above 9 are blanked
   function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [DIGIT_W-1:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_stable_sampler.sv
// Synchronises an asynchronous 4-bit code and accepts each new code once it
// has been stable long enough to rule out ripple intermediates.
module bcd_stable_sampler
   import bcd_disp_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 2
) (
   input  logic               clock,
   input  logic               clear,
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] code,
   output logic               accept
);

   localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [DIGIT_W-1:0] sync_q [SYNC_STAGES];
   logic [DIGIT_W-1:0] s;
   logic [DIGIT_W-1:0] s_next;
   logic [DIGIT_W-1:0] last;
   logic [CNT_W-1:0]   same;
   logic [CNT_W-1:0]   same_next;
   logic               take_c;

   // The stage feeding s is a look-ahead of s, so the run length can be
   // judged for the value s is about to hold and acceptance needs no extra flop.
   assign s      = sync_q[SYNC_STAGES-1];
   assign s_next = sync_q[SYNC_STAGES-2];

   // Run-length of s (saturating) and acceptance decision
   always_comb begin
      same_next = '0;
      take_c    = 1'b0;
      if (s_next != s) begin
         same_next = '0;
      end else if (same == CNT_MAX) begin
         same_next = same;
      end else begin
         same_next = same + CNT_W'(1);
      end
      take_c = (same_next == CNT_MAX) && (s_next != last);
   end

   // Synchroniser chain
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= d;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Filter state and one-cycle accept pulse
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         same   <= '0;
         last   <= '0;
         code   <= '0;
         accept <= 1'b0;
      end else begin
         same   <= same_next;
         accept <= take_c;
         if (take_c) begin
            code <= s_next;
            last <= s_next;
         end
      end
   end

endmodule

// File: rtl/bcd_sync_display.sv
// Ripple-counter consumer: resynchronise, filter, extend with a tens digit
// and drive a two-digit multiplexed 7-segment display.
module bcd_sync_display
   import bcd_disp_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned REFRESH_DIV   = 4
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               Y0,
   input  logic               Y1,
   input  logic               Y2,
   input  logic               Y3,
   output logic [DIGIT_W-1:0] ones,
   output logic [DIGIT_W-1:0] tens,
   output logic               valid,
   output logic               wrap_pulse,
   output logic               carry_out,
   output logic               err,
   output logic [SEG_W-1:0]   seg,
   output logic [AN_W-1:0]    an
);

   localparam int unsigned REF_W = $clog2(REFRESH_DIV);
   localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

   logic [DIGIT_W-1:0] code;
   logic               accept;
   bcd_pair_t          cnt_q;
   bcd_pair_t          cnt_n;
   logic               valid_n;
   logic               err_n;
   logic               wrap_n;
   logic               carry_n;
   logic [REF_W-1:0]   ref_cnt;
   logic [REF_W-1:0]   ref_n;
   logic [AN_W-1:0]    an_n;
   logic [SEG_W-1:0]   seg_n;

   bcd_stable_sampler #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_sampler (
      .clock  (clock),
      .clear  (clear),
      .d      ({Y3, Y2, Y1, Y0}),
      .code   (code),
      .accept (accept)
   );

   assign ones = cnt_q.ones;
   assign tens = cnt_q.tens;

   // Next digit state, refresh position and segment pattern; seg is decoded
   // from next-state values so it always matches the digit an selects.
   always_comb begin
      cnt_n   = cnt_q;
      valid_n = valid;
      err_n   = err;
      wrap_n  = 1'b0;
      carry_n = 1'b0;
      if (accept) begin
         if (code <= 4'd9) begin
            if ((code == 4'd0) && (cnt_q.ones == 4'd9) && valid) begin
               wrap_n     = 1'b1;
               carry_n    = (cnt_q.tens == 4'd9);
               cnt_n.tens = (cnt_q.tens == 4'd9) ? 4'd0 : cnt_q.tens + 4'd1;
            end
            cnt_n.ones = code;
            valid_n    = 1'b1;
         end else begin
            err_n = 1'b1;
         end
      end

      ref_n = (ref_cnt == REF_MAX) ? '0 : ref_cnt + REF_W'(1);
      an_n  = (ref_cnt == REF_MAX) ? ~an : an;
      seg_n = valid_n ? bcd_to_seg((an_n == AN_ONES) ? cnt_n.ones : cnt_n.tens)
                      : SEG_BLANK;
   end

   // Digit, status and display registers
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         cnt_q      <= '0;
         valid      <= 1'b0;
         err        <= 1'b0;
         wrap_pulse <= 1'b0;
         carry_out  <= 1'b0;
         ref_cnt    <= '0;
         an         <= AN_ONES;
         seg        <= SEG_BLANK;
      end else begin
         cnt_q      <= cnt_n;
         valid      <= valid_n;
         err        <= err_n;
         wrap_pulse <= wrap_n;
         carry_out  <= carry_n;
         ref_cnt    <= ref_n;
         an         <= an_n;
         seg        <= seg_n;
      end
   end

endmodule

// File: tb/tb_bcd_sync_display.sv
// Scoreboard bench for bcd_sync_display: stimulus queues expected digit
// events, a monitor matches them against observed output changes.
module tb_bcd_sync_display;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic       Y0 = 1'b0, Y1 = 1'b0, Y2 = 1'b0, Y3 = 1'b0;
   logic [3:0] ones, tens;
   logic       valid, wrap_pulse, carry_out, err;
   logic [6:0] seg;
   logic [1:0] an;

   typedef struct packed {
      int         cyc;
      logic [3:0] ones;
      logic [3:0] tens;
      logic       valid;
      logic       err;
      logic       wrap;
      logic       carry;
   } exp_t;

   exp_t       q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         an_edges = 0;
   logic [3:0] m_ones = '0, m_tens = '0;
   logic       m_valid = 1'b0;
   logic [6:0] lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   bcd_sync_display dut (
      .clock      (clock),
      .clear      (clear),
      .Y0         (Y0),
      .Y1         (Y1),
      .Y2         (Y2),
      .Y3         (Y3),
      .ones       (ones),
      .tens       (tens),
      .valid      (valid),
      .wrap_pulse (wrap_pulse),
      .carry_out  (carry_out),
      .err        (err),
      .seg        (seg),
      .an         (an)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Edges since clear released, used to predict the digit enable
   always @(posedge clock or posedge clear) begin
      if (clear) an_edges <= 0;
      else       an_edges <= an_edges + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drive a code for 'hold' cycles; queue its expected effect if any
   task automatic apply(input logic [3:0] v, input int hold, input bit ev,
                        input logic [3:0] e_ones, input logic [3:0] e_tens,
                        input bit e_valid, input bit e_err, input bit e_wrap, input bit e_carry);
      exp_t e;
      @(negedge clock);
      {Y3, Y2, Y1, Y0} = v;
      if (ev) begin
         e.cyc   = cyc + 4;
         e.ones  = e_ones;
         e.tens  = e_tens;
         e.valid = e_valid;
         e.err   = e_err;
         e.wrap  = e_wrap;
         e.carry = e_carry;
         q.push_back(e);
      end
      repeat (hold - 1) @(negedge clock);
   endtask

   // Monitor: match output events to queued expectations, check display
   initial begin
      logic [9:0] prev;
      logic [9:0] obs;
      logic [1:0] exp_an;
      exp_t       e;
      prev = '0;
      forever begin
         @(negedge clock);
         obs = {ones, tens, valid, err};
         if (clear) begin
            prev    = '0;
            m_ones  = '0;
            m_tens  = '0;
            m_valid = 1'b0;
         end else begin
            if ((obs !== prev) || wrap_pulse || carry_out) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_event: got %0h wrap=%0b carry=%0b want no change (cycle %0d)",
                           obs, wrap_pulse, carry_out, cyc);
               end else begin
                  e = q.pop_front();
                  chk("event_cycle", 32'(cyc), 32'(e.cyc));
                  chk("event_value", 32'({ones, tens, valid, err, wrap_pulse, carry_out}),
                      32'({e.ones, e.tens, e.valid, e.err, e.wrap, e.carry}));
                  m_ones  = e.ones;
                  m_tens  = e.tens;
                  m_valid = e.valid;
               end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
               e = q.pop_front();
               n_cmp++;
               n_bad++;
               $display("FAIL missing_event: got %0h want %0h by cycle %0d",
                        obs, {e.ones, e.tens, e.valid, e.err}, e.cyc);
               m_ones  = e.ones;
               m_tens  = e.tens;
               m_valid = e.valid;
            end
            prev = obs;
         end
         exp_an = (((an_edges / 4) % 2) == 1) ? 2'b10 : 2'b01;
         chk("an", 32'(an), 32'(exp_an));
         chk("seg", 32'(seg), 32'(m_valid ? lut[(exp_an == 2'b01) ? m_ones : m_tens] : 7'h00));
      end
   end

   // Directed stimulus
   initial begin
      // 1: reset state, then code 0 is never accepted
      repeat (3) @(negedge clock);
      chk("rst_digits", 32'({ones, tens}), 32'h0);
      chk("rst_flags", 32'({valid, wrap_pulse, carry_out, err}), 32'h0);
      chk("rst_seg", 32'(seg), 32'h00);
      chk("rst_an", 32'(an), 32'h1);
      #2 clear = 1'b0;
      repeat (10) @(negedge clock);
      chk("idle_valid", 32'(valid), 32'h0);

      // 2: count 1..9
      for (int c = 1; c <= 9; c++) begin
         apply(4'(c), 8, 1'b1, 4'(c), 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
         if (c == 1) begin
            for (int i = 0; i < 8 && an != 2'b01; i++) @(negedge clock);
            chk("seg_one_an", 32'(an), 32'h1);
            chk("seg_one", 32'(seg), 32'h06);
         end
      end

      // 3: ten 9->0 wraps, tens 1..9 then 0 with carry
      for (int i = 1; i <= 10; i++) begin
         apply(4'd0, 8, 1'b1, 4'd0, 4'(i % 10), 1'b1, 1'b0, 1'b1, (i == 10));
         apply(4'd9, 8, 1'b1, 4'd9, 4'(i % 10), 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // 4: ripple glitch 7->6->4->0 -> 8, only 7 and 8 accepted
      apply(4'd7, 8, 1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      apply(4'd6, 1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply(4'd4, 1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply(4'd0, 1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply(4'd8, 8, 1'b1, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("glitch_err", 32'(err), 32'h0);

      // 5: illegal code sets sticky err only
      apply(4'd12, 5, 1'b1, 4'd8, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("bad_err", 32'(err), 32'h1);
      chk("bad_ones", 32'(ones), 32'h8);
      apply(4'd9, 8, 1'b1, 4'd9, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("err_sticky", 32'(err), 32'h1);

      // 6: clear during a pending 9->0 acceptance
      @(negedge clock);
      {Y3, Y2, Y1, Y0} = 4'd0;
      repeat (2) @(negedge clock);
      #2 clear = 1'b1;
      repeat (2) @(negedge clock);
      #2 clear = 1'b0;
      repeat (12) @(negedge clock);
      chk("abort_digits", 32'({ones, tens}), 32'h0);
      chk("abort_flags", 32'({valid, wrap_pulse, carry_out, err}), 32'h0);
      chk("abort_seg", 32'(seg), 32'h00);

      repeat (6) @(negedge clock);
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
